// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the per-axis timing helper used by
// vga_axis_counter and vga_timing_gen.
package vga_timing_pkg;

  // 800x600@60 (40 MHz pixel clock), the generator's default mode
  localparam int unsigned DEF_CNT_W    = 11;
  localparam int unsigned DEF_H_ACTIVE = 800;
  localparam int unsigned DEF_H_FP     = 40;
  localparam int unsigned DEF_H_SYNC   = 128;
  localparam int unsigned DEF_H_BP     = 88;
  localparam int unsigned DEF_V_ACTIVE = 600;
  localparam int unsigned DEF_V_FP     = 1;
  localparam int unsigned DEF_V_SYNC   = 4;
  localparam int unsigned DEF_V_BP     = 23;
  localparam bit          DEF_HS_POL   = 1'b1;
  localparam bit          DEF_VS_POL   = 1'b1;
  localparam int unsigned DEF_FCNT_W   = 16;

  // 640x480@60 (25.175 MHz), 800x525 total, negative syncs
  localparam int unsigned VGA640_H_ACTIVE = 640;
  localparam int unsigned VGA640_H_FP     = 16;
  localparam int unsigned VGA640_H_SYNC   = 96;
  localparam int unsigned VGA640_H_BP     = 48;
  localparam int unsigned VGA640_V_ACTIVE = 480;
  localparam int unsigned VGA640_V_FP     = 10;
  localparam int unsigned VGA640_V_SYNC   = 2;
  localparam int unsigned VGA640_V_BP     = 33;
  localparam bit          VGA640_HS_POL   = 1'b0;
  localparam bit          VGA640_VS_POL   = 1'b0;

  typedef struct packed {
    logic [31:0] total;
    logic [31:0] sync_start;
    logic [31:0] sync_end;
  } axis_timing_t;

  function automatic axis_timing_t axis_timing(input int unsigned active,
                                               input int unsigned fp,
                                               input int unsigned sync,
                                               input int unsigned bp);
    axis_timing_t t;
    t.sync_start = active + fp;
    t.sync_end   = t.sync_start + sync;
    t.total      = t.sync_end + bp;
    return t;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrapping position counter plus blanking and sync levels,
// all registered and derived from the next-state count so they stay aligned.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned WIDTH  = DEF_CNT_W,
  parameter int unsigned ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned FP     = DEF_H_FP,
  parameter int unsigned SYNC   = DEF_H_SYNC,
  parameter int unsigned BP     = DEF_H_BP,
  parameter bit          POL    = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             advance,
  output logic [WIDTH-1:0] count,
  output logic             blnk,
  output logic             sync,
  output logic             wrap
);

  localparam axis_timing_t     TIM     = axis_timing(ACTIVE, FP, SYNC, BP);
  localparam logic [WIDTH-1:0] LAST    = WIDTH'(TIM.total - 32'd1);
  localparam logic [WIDTH-1:0] ACT     = WIDTH'(ACTIVE);
  localparam logic [WIDTH-1:0] S_START = WIDTH'(TIM.sync_start);
  localparam logic [WIDTH-1:0] S_END   = WIDTH'(TIM.sync_end);

  if (ACTIVE == 0 || FP == 0 || SYNC == 0 || BP == 0) begin : g_zero_width
    $error("vga_axis_counter: active, porch and sync widths must be non-zero");
  end
  if (((TIM.total - 32'd1) >> WIDTH) != 32'd0) begin : g_width_too_small
    $error("vga_axis_counter: WIDTH cannot hold total-1");
  end

  logic [WIDTH-1:0] count_q, count_d;
  logic             blnk_q, blnk_d;
  logic             sync_q, sync_d;

  always_comb begin
    count_d = count_q;
    if (advance) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
    blnk_d = (count_d >= ACT);
    sync_d = ((count_d >= S_START) && (count_d < S_END)) ? POL : ~POL;
  end

  // Reset state matches count 0: visible, sync inactive
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      blnk_q  <= blnk_d;
      sync_q  <= sync_d;
    end
  end

  assign count = count_q;
  assign blnk  = blnk_q;
  assign sync  = sync_q;
  assign wrap  = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: h/v counters, sync, blanking, data
// enable, line/frame start markers and a completed-frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned CNT_W    = DEF_CNT_W,
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          HS_POL   = DEF_HS_POL,
  parameter bit          VS_POL   = DEF_VS_POL,
  parameter int unsigned FCNT_W   = DEF_FCNT_W
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              pix_en,
  output logic [CNT_W-1:0]  hcount,
  output logic [CNT_W-1:0]  vcount,
  output logic              hsync,
  output logic              vsync,
  output logic              hblnk,
  output logic              vblnk,
  output logic              de,
  output logic              sol,
  output logic              sof,
  output logic [FCNT_W-1:0] frame_cnt
);

  logic h_wrap, v_wrap, v_adv, frame_done;

  vga_axis_counter #(
    .WIDTH(CNT_W), .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HS_POL)
  ) u_h_axis (
    .clk(pclk), .rst_n(rst_n), .advance(pix_en),
    .count(hcount), .blnk(hblnk), .sync(hsync), .wrap(h_wrap)
  );

  assign v_adv = pix_en & h_wrap;

  vga_axis_counter #(
    .WIDTH(CNT_W), .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VS_POL)
  ) u_v_axis (
    .clk(pclk), .rst_n(rst_n), .advance(v_adv),
    .count(vcount), .blnk(vblnk), .sync(vsync), .wrap(v_wrap)
  );

  assign frame_done = v_adv & v_wrap;

  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (frame_done) begin
      frame_cnt_d = frame_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign frame_cnt = frame_cnt_q;
  assign de        = ~(hblnk | vblnk);

  // Markers fire on the strobe cycle that consumes position 0, so a divided
  // clock sees exactly one pulse; rst_n gating keeps them low during reset.
  assign sol = rst_n & pix_en & (hcount == '0);
  assign sof = sol & (vcount == '0);

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: small positive-sync mode (A), small
// negative-sync mode (B) and the default 800x600 mode (C).
module tb_vga_timing_gen;

  logic pclk = 1'b0;
  logic rst_n;
  logic pix_en_a, pix_en_b, pix_en_c;

  always #5 pclk = ~pclk;

  // Mode A: H 8/2/3/3 (total 16, hsync 10..12), V 6/1/2/2 (total 11, vsync 7..8)
  logic [4:0] hcount_a, vcount_a;
  logic hsync_a, vsync_a, hblnk_a, vblnk_a, de_a, sol_a, sof_a;
  logic [1:0] frame_cnt_a;

  vga_timing_gen #(
    .CNT_W(5), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(2),
    .HS_POL(1'b1), .VS_POL(1'b1), .FCNT_W(2)
  ) dut_a (
    .pclk(pclk), .rst_n(rst_n), .pix_en(pix_en_a),
    .hcount(hcount_a), .vcount(vcount_a), .hsync(hsync_a), .vsync(vsync_a),
    .hblnk(hblnk_a), .vblnk(vblnk_a), .de(de_a), .sol(sol_a), .sof(sof_a),
    .frame_cnt(frame_cnt_a)
  );

  // Mode B: H 10/1/2/1 (total 14, hsync 11..12), V 4/2/1/3 (total 10, vsync 6)
  logic [3:0] hcount_b, vcount_b;
  logic hsync_b, vsync_b, hblnk_b, vblnk_b, de_b, sol_b, sof_b;
  logic [3:0] frame_cnt_b;

  vga_timing_gen #(
    .CNT_W(4), .H_ACTIVE(10), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(2), .V_SYNC(1), .V_BP(3),
    .HS_POL(1'b0), .VS_POL(1'b0), .FCNT_W(4)
  ) dut_b (
    .pclk(pclk), .rst_n(rst_n), .pix_en(pix_en_b),
    .hcount(hcount_b), .vcount(vcount_b), .hsync(hsync_b), .vsync(vsync_b),
    .hblnk(hblnk_b), .vblnk(vblnk_b), .de(de_b), .sol(sol_b), .sof(sof_b),
    .frame_cnt(frame_cnt_b)
  );

  logic [10:0] hcount_c, vcount_c;
  logic hsync_c, vsync_c, hblnk_c, vblnk_c, de_c, sol_c, sof_c;
  logic [15:0] frame_cnt_c;

  vga_timing_gen dut_c (
    .pclk(pclk), .rst_n(rst_n), .pix_en(pix_en_c),
    .hcount(hcount_c), .vcount(vcount_c), .hsync(hsync_c), .vsync(vsync_c),
    .hblnk(hblnk_c), .vblnk(vblnk_c), .de(de_c), .sol(sol_c), .sof(sof_c),
    .frame_cnt(frame_cnt_c)
  );

  int checks = 0;
  int errors = 0;

  // Reference position for mode A
  int eh = 0;
  int ev = 0;
  logic [1:0] ef = 2'd0;

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic apply_reset();
    tick();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic model_a_step(input logic pe);
    if (pe) begin
      if (eh == 15) begin
        eh = 0;
        if (ev == 10) begin
          ev = 0;
          ef = ef + 2'd1;
        end else begin
          ev = ev + 1;
        end
      end else begin
        eh = eh + 1;
      end
    end
  endtask

  // {hsync, vsync, hblnk, vblnk, de, sol, sof} expected for mode A
  function automatic logic [6:0] exp_flags_a(input logic pe);
    logic hs, vs, hb, vb;
    hs = (eh >= 10) && (eh < 13);
    vs = (ev >= 7) && (ev < 9);
    hb = (eh >= 8);
    vb = (ev >= 6);
    return {hs, vs, hb, vb, !(hb || vb), pe && (eh == 0), pe && (eh == 0) && (ev == 0)};
  endfunction

  task automatic test_reset();
    rst_n = 1'b1;
    pix_en_a = 1'b1;
    pix_en_b = 1'b1;
    pix_en_c = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hcount_a, vcount_a, frame_cnt_a} !== 12'd0) begin
      errors++;
      $display("FAIL reset_counts_a: got h=%0d v=%0d f=%0d, expected 0/0/0", hcount_a, vcount_a, frame_cnt_a);
    end
    checks++;
    if ({hsync_a, vsync_a, hblnk_a, vblnk_a, de_a, sol_a, sof_a} !== 7'b0000100) begin
      errors++;
      $display("FAIL reset_flags_a: got %b, expected 0000100", {hsync_a, vsync_a, hblnk_a, vblnk_a, de_a, sol_a, sof_a});
    end
    checks++;
    if ({hsync_b, vsync_b, de_b, hcount_b, vcount_b, frame_cnt_b} !== {3'b111, 12'd0}) begin
      errors++;
      $display("FAIL reset_b: got hs=%b vs=%b de=%b h=%0d v=%0d f=%0d, expected hs=1 vs=1 de=1 zeros", hsync_b, vsync_b, de_b, hcount_b, vcount_b, frame_cnt_b);
    end
    checks++;
    if ({hsync_c, vsync_c, de_c, hcount_c, frame_cnt_c} !== {3'b001, 27'd0}) begin
      errors++;
      $display("FAIL reset_c: got hs=%b vs=%b de=%b h=%0d f=%0d, expected hs=0 vs=0 de=1 zeros", hsync_c, vsync_c, de_c, hcount_c, frame_cnt_c);
    end
    tick();
    tick();
    rst_n = 1'b1;
    #1;
    checks++;
    if ({sol_a, sof_a, hcount_a, vcount_a} !== {2'b11, 10'd0}) begin
      errors++;
      $display("FAIL first_sof_a: got sol=%b sof=%b h=%0d v=%0d, expected sol=1 sof=1 h=0 v=0", sol_a, sof_a, hcount_a, vcount_a);
    end
    eh = 0;
    ev = 0;
    ef = 2'd0;
  endtask

  task automatic test_frame_a();
    int sof_n = 0;
    int sol_n = 0;
    for (int i = 0; i < 704; i++) begin
      pix_en_a = 1'b1;
      #1;
      checks++;
      if ({hcount_a, vcount_a, frame_cnt_a} !== {5'(eh), 5'(ev), ef}) begin
        errors++;
        $display("FAIL frame_a_counts cyc %0d: got h=%0d v=%0d f=%0d, expected h=%0d v=%0d f=%0d", i, hcount_a, vcount_a, frame_cnt_a, eh, ev, ef);
      end
      checks++;
      if ({hsync_a, vsync_a, hblnk_a, vblnk_a, de_a, sol_a, sof_a} !== exp_flags_a(1'b1)) begin
        errors++;
        $display("FAIL frame_a_flags cyc %0d h=%0d v=%0d: got %b, expected %b", i, eh, ev, {hsync_a, vsync_a, hblnk_a, vblnk_a, de_a, sol_a, sof_a}, exp_flags_a(1'b1));
      end
      if (sof_a === 1'b1) sof_n++;
      if (sol_a === 1'b1) sol_n++;
      tick();
      model_a_step(1'b1);
    end
    checks++;
    if (sof_n != 4 || sol_n != 44) begin
      errors++;
      $display("FAIL frame_a_pulses: got sof=%0d sol=%0d, expected sof=4 sol=44", sof_n, sol_n);
    end
    checks++;
    if ({frame_cnt_a, hcount_a, vcount_a} !== 12'd0) begin
      errors++;
      $display("FAIL frame_cnt_wrap_a: got f=%0d h=%0d v=%0d, expected 0/0/0", frame_cnt_a, hcount_a, vcount_a);
    end
  endtask

  task automatic test_pixdiv();
    int sol_n = 0;
    int sol_at[2] = '{-1, -1};
    logic pe;
    for (int i = 0; i < 64; i++) begin
      pe = (i % 2 == 0);
      pix_en_a = pe;
      #1;
      checks++;
      if ({hcount_a, vcount_a} !== {5'(eh), 5'(ev)}) begin
        errors++;
        $display("FAIL pixdiv_counts cyc %0d: got h=%0d v=%0d, expected h=%0d v=%0d", i, hcount_a, vcount_a, eh, ev);
      end
      checks++;
      if ({hsync_a, vsync_a, hblnk_a, vblnk_a, de_a, sol_a, sof_a} !== exp_flags_a(pe)) begin
        errors++;
        $display("FAIL pixdiv_flags cyc %0d: got %b, expected %b", i, {hsync_a, vsync_a, hblnk_a, vblnk_a, de_a, sol_a, sof_a}, exp_flags_a(pe));
      end
      if (sol_a === 1'b1) begin
        if (sol_n < 2) sol_at[sol_n] = i;
        sol_n++;
      end
      tick();
      model_a_step(pe);
    end
    checks++;
    if (sol_n != 2 || sol_at[1] - sol_at[0] != 32) begin
      errors++;
      $display("FAIL pixdiv_line_period: got %0d sol pulses at %0d,%0d, expected 2 pulses 32 clocks apart", sol_n, sol_at[0], sol_at[1]);
    end
    pix_en_a = 1'b1;
  endtask

  task automatic test_async_reset();
    bit found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      pix_en_a = 1'b1;
      tick();
      model_a_step(1'b1);
      found = (eh == 12) && (ev == 7) && (ef == 2'd1);
    end
    checks++;
    if (!found || {hcount_a, vcount_a, frame_cnt_a, hsync_a, vsync_a} !== {5'd12, 5'd7, 2'd1, 2'b11}) begin
      errors++;
      $display("FAIL pre_reset_pos: found=%0d got h=%0d v=%0d f=%0d hs=%b vs=%b, expected h=12 v=7 f=1 hs=1 vs=1", found, hcount_a, vcount_a, frame_cnt_a, hsync_a, vsync_a);
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({hcount_a, vcount_a, frame_cnt_a, hsync_a, vsync_a, sof_a} !== 15'd0) begin
      errors++;
      $display("FAIL async_reset_a: got h=%0d v=%0d f=%0d hs=%b vs=%b sof=%b, expected all 0", hcount_a, vcount_a, frame_cnt_a, hsync_a, vsync_a, sof_a);
    end
    checks++;
    if ({hsync_b, vsync_b} !== 2'b11) begin
      errors++;
      $display("FAIL async_reset_b_sync: got hs=%b vs=%b, expected inactive 1/1", hsync_b, vsync_b);
    end
    tick();
    pix_en_a = 1'b0;
    tick();
    rst_n = 1'b1;
    eh = 0;
    ev = 0;
    ef = 2'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if ({sof_a, sol_a, hcount_a} !== 7'd0) begin
        errors++;
        $display("FAIL idle_after_reset cyc %0d: got sof=%b sol=%b h=%0d, expected 0/0/0", i, sof_a, sol_a, hcount_a);
      end
      tick();
    end
    pix_en_a = 1'b1;
    #1;
    checks++;
    if ({sof_a, hcount_a, vcount_a} !== 11'b1_00000_00000) begin
      errors++;
      $display("FAIL first_pix_en_sof: got sof=%b h=%0d v=%0d, expected sof=1 h=0 v=0", sof_a, hcount_a, vcount_a);
    end
    tick();
    checks++;
    if ({sof_a, hcount_a} !== 6'd1) begin
      errors++;
      $display("FAIL after_first_sof: got sof=%b h=%0d, expected sof=0 h=1", sof_a, hcount_a);
    end
  endtask

  task automatic test_neg_pol_b();
    int bh = 0;
    int bv = 0;
    int de_n = 0;
    int hs_lo = 0;
    int vs_lo = 0;
    pix_en_b = 1'b1;
    apply_reset();
    for (int i = 0; i < 140; i++) begin
      #1;
      checks++;
      if ({hcount_b, vcount_b} !== {4'(bh), 4'(bv)}) begin
        errors++;
        $display("FAIL neg_b_counts cyc %0d: got h=%0d v=%0d, expected h=%0d v=%0d", i, hcount_b, vcount_b, bh, bv);
      end
      checks++;
      if ({hsync_b, vsync_b, de_b} !== {!(bh >= 11 && bh < 13), !(bv == 6), (bh < 10 && bv < 4)}) begin
        errors++;
        $display("FAIL neg_b_flags cyc %0d h=%0d v=%0d: got hs=%b vs=%b de=%b", i, bh, bv, hsync_b, vsync_b, de_b);
      end
      if (de_b === 1'b1) de_n++;
      if (hsync_b === 1'b0) hs_lo++;
      if (vsync_b === 1'b0) vs_lo++;
      tick();
      if (bh == 13) begin
        bh = 0;
        bv = (bv == 9) ? 0 : bv + 1;
      end else begin
        bh = bh + 1;
      end
    end
    checks++;
    if (de_n != 40 || hs_lo != 20 || vs_lo != 14) begin
      errors++;
      $display("FAIL neg_b_totals: got de=%0d hs_low=%0d vs_low=%0d, expected 40/20/14", de_n, hs_lo, vs_lo);
    end
    checks++;
    if ({frame_cnt_b, hcount_b, vcount_b} !== {4'd1, 8'd0}) begin
      errors++;
      $display("FAIL neg_b_frame: got f=%0d h=%0d v=%0d, expected f=1 h=0 v=0", frame_cnt_b, hcount_b, vcount_b);
    end
  endtask

  task automatic test_default_c();
    int ch, cv;
    int hs_hi = 0;
    int sol_n = 0;
    logic hb;
    pix_en_c = 1'b1;
    apply_reset();
    for (int i = 0; i < 2112; i++) begin
      ch = i % 1056;
      cv = i / 1056;
      hb = (ch >= 800);
      #1;
      checks++;
      if ({hcount_c, vcount_c} !== {11'(ch), 11'(cv)}) begin
        errors++;
        $display("FAIL default_counts cyc %0d: got h=%0d v=%0d, expected h=%0d v=%0d", i, hcount_c, vcount_c, ch, cv);
      end
      checks++;
      if ({hsync_c, vsync_c, hblnk_c, vblnk_c, de_c, sol_c, sof_c} !==
          {(ch >= 840 && ch < 968), 1'b0, hb, 1'b0, !hb, ch == 0, ch == 0 && cv == 0}) begin
        errors++;
        $display("FAIL default_flags cyc %0d h=%0d: got %b", i, ch, {hsync_c, vsync_c, hblnk_c, vblnk_c, de_c, sol_c, sof_c});
      end
      if (hsync_c === 1'b1) hs_hi++;
      if (sol_c === 1'b1) sol_n++;
      tick();
    end
    checks++;
    if (hs_hi != 256 || sol_n != 2) begin
      errors++;
      $display("FAIL default_totals: got hsync_high=%0d sol=%0d, expected 256/2", hs_hi, sol_n);
    end
    checks++;
    if ({hcount_c, vcount_c, frame_cnt_c} !== {11'd0, 11'd2, 16'd0}) begin
      errors++;
      $display("FAIL default_end: got h=%0d v=%0d f=%0d, expected h=0 v=2 f=0", hcount_c, vcount_c, frame_cnt_c);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_frame_a();
    test_pixdiv();
    test_async_reset();
    test_neg_pol_b();
    test_default_c();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised successor to the fixed 800x600 VGA timing generator. Produces horizontal and vertical counters, sync, blanking, data-enable and frame/line markers for any mode defined by parameters. Supports configurable sync polarity and a pixel-enable strobe for divided pixel clocks. Sits between the clock/reset logic and the drawing/background pipeline, which consume hcount/vcount and the delayed sync/blank signals.

Parameters:
CNT_W, 11, width of hcount/vcount; must satisfy 2^CNT_W > max(H_TOTAL, V_TOTAL)-1
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch, in pixels
H_SYNC, 128, horizontal sync width, in pixels
H_BP, 88, horizontal back porch, in pixels
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch, in lines
V_SYNC, 4, vertical sync width, in lines
V_BP, 23, vertical back porch, in lines
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
FCNT_W, 16, frame counter width

Ports:
pclk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pix_en  in  1  advance strobe; tie to 1 for one pixel per clock
hcount  out  CNT_W  horizontal position, 0..H_TOTAL-1
vcount  out  CNT_W  vertical position, 0..V_TOTAL-1
hsync  out  1  horizontal sync, level set by HS_POL
vsync  out  1  vertical sync, level set by VS_POL
hblnk  out  1  high when hcount >= H_ACTIVE
vblnk  out  1  high when vcount >= V_ACTIVE
de  out  1  ~hblnk & ~vblnk
sol  out  1  one-cycle pulse when hcount==0, qualified by pix_en
sof  out  1  one-cycle pulse when hcount==0 && vcount==0, qualified by pix_en
frame_cnt  out  FCNT_W  completed frames, wraps modulo 2^FCNT_W

Behaviour:
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; HS_START = H_ACTIVE+H_FP; HS_END = HS_START+H_SYNC. V_* constants are derived the same way.
- Reset (rst_n low, asynchronous): hcount=0, vcount=0, frame_cnt=0, hblnk=vblnk=0, de=1, hsync=~HS_POL, vsync=~VS_POL, sol=sof=0.
- First deassertion edge: the counters start from (0,0). No pre-roll frame.
- All outputs are registered and mutually aligned: every flag matches the hcount/vcount values on the same cycle. Flags are computed from next-state counts.
- pix_en=0: all counters and levels hold. sol and sof are 0.
- pix_en=1:
  - hcount increments.
  - When hcount==H_TOTAL-1: hcount wraps to 0 and vcount advances.
  - When vcount==V_TOTAL-1 at the line wrap: vcount wraps to 0 and frame_cnt increments.
- Sync windows are half-open:
  - hsync is active for HS_START <= hcount < HS_END.
  - vsync is active for VS_START <= vcount < VS_END.
- frame_cnt wraps from all-ones to 0 without a flag.
- Reset asserted mid-frame: immediate return to reset values. Sync outputs go inactive asynchronously.
- Counter arithmetic is unsigned CNT_W bits. A parameter violating the CNT_W rule, or any zero porch/sync/active width, is a fatal elaboration error (generate-time $error).

Decomposition:
- Package vga_timing_pkg holds:
  - default 800x600@60 mode constants (the parameter defaults above);
  - the 640x480@60 constant set (800/525 total; 16/96/48; 10/2/33);
  - a function computing totals and sync start/end from active/porch/sync widths.
- Sub-module vga_axis_counter, instantiated twice:
  - Parameters: width, active, fp, sync, bp, polarity.
  - Inputs: clock, reset, advance.
  - Outputs: count, blnk, sync, wrap (terminal-count).
  - The horizontal instance has advance=pix_en. The vertical instance has advance=pix_en & h_wrap.
- The top level adds de, sol, sof and frame_cnt.

Test Plan:
- Defaults, pix_en=1, run 2 frames -> 1056 clocks per line; 628 lines per frame. hsync high hcount 840..967 (128 clks); vsync high vcount 601..604. sof every 663168 clks; frame_cnt 0->1->2.
- Params set to 640x480, HS_POL=VS_POL=0 -> H_TOTAL=800, V_TOTAL=525. hsync low exactly hcount 656..751; vsync low vcount 490..491. de count per frame 307200.
- pix_en toggling 1,0 (divide-by-2) -> every count value held exactly 2 clks. Line period 2112 clks. sol/sof asserted on 1 of the 2 cycles only.
- rst_n low at hcount=500,vcount=300 -> same-cycle (async) hcount=0, vcount=0, hsync/vsync inactive, frame_cnt=0. After release, the first sof occurs on the first pix_en cycle.
- Boundary: at hcount=1055,vcount=627 with pix_en=1 -> next cycle hcount=0, vcount=0, sof=1, frame_cnt+1. With FCNT_W=2 after 4 frames -> frame_cnt=0.
- Alignment check every cycle -> hblnk==(hcount>=H_ACTIVE), vblnk==(vcount>=V_ACTIVE), de==~(hblnk|vblnk). No one-cycle skew allowed.
